i2c_regxfer: RTL and testbench
==============================

# i2c_regxfer

Register-transfer sequencer sitting directly upstream of `i2c_master`. It accepts one host request (7-bit device address, 8-bit register address, direction, byte count) and breaks it into the master's byte-level command writes. It handles START, address, register pointer, repeated START, data bytes, ACK/NACK and STOP. It streams write data in, streams read data out, and reports a single error code per transfer.

## Interface
Parameters
- `MAXLEN_LD`, 4: width of `len`; a transfer moves 1..2^MAXLEN_LD bytes.

Ports
- `clk`  in  1  system clock, same clock as `i2c_master`.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  start request; sampled only in IDLE.
- `dev`  in  7  device address; latched on accepted `go`.
- `rega`  in  8  register address; latched on accepted `go`.
- `rnw`  in  1  1 = read, 0 = write; latched on accepted `go`.
- `len`  in  MAXLEN_LD  byte count minus 1; latched on accepted `go`.
- `wdat`  in  8  write data byte.
- `wdat_vld`  in  1  `wdat` valid.
- `wdat_rdy`  out  1  sequencer takes `wdat` this cycle when `wdat_vld` is also high.
- `rdat`  out  8  read data byte.
- `rdat_vld`  out  1  one-cycle pulse; `rdat` valid; no backpressure.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at end of transfer.
- `err`  out  3  result code, held until the next accepted `go`: 0 ok, 1 address NACK, 2 register/data NACK, 3 arbitration lost, 4 bus busy, 5 protocol error.
- `m_cmd`  out  `C_SZ`  command to the master (encodings from `i2c-master.vh`).
- `m_dat`  out  8  byte to the master.
- `m_ws`  out  1  command write strobe.
- `m_stat`  in  `S_SZ`  master status.
- `m_dat_in`  in  8  master read byte.

## Operation
- FSM states: IDLE, ISSUE, SETTLE, WAIT, EVAL, FETCH, ABORT, ABWAIT, FIN.
- Phase register: AW (address+W), RG (register), AR (address+R), DT (data). Byte counter `cnt` is MAXLEN_LD bits wide and counts down to 0.
- IDLE: on `go`, latch the request, clear `err`, set `busy`, set phase AW, go to ISSUE.
- ISSUE: wait until `m_stat[SB_BSY]==0`, then drive `m_ws=1` for one cycle with `m_cmd`/`m_dat`, then go to SETTLE.
  - AW: `C_STRT|C_WRTE`, `{dev,0}`.
  - RG: `C_WRTE`, `rega`.
  - AR: `C_STRT|C_WRTE`, `{dev,1}` (repeated START).
  - DT write: `C_WRTE`, plus `C_STOP` when `cnt==0`; byte comes from the fetched data.
  - DT read: `C_READ`, plus `C_NACK|C_STOP` when `cnt==0`.
- SETTLE: one cycle; the master status updates. Then go to WAIT.
- WAIT: hold until `m_status[SB_DON]==1 && [SB_BSY]==0`, then go to EVAL.
- EVAL, checked in priority order:
  - `S_ALO` → err 3, go to FIN.
  - `S_BBL` → err 4, go to FIN.
  - `S_ERR` (other) → err 5, go to FIN.
  - Phase not DT-read and `SB_ACK==0` → err 1 in AW/AR, err 2 in RG/DT. Go to ABORT, unless this was the last write byte: its STOP is already sent, so go to FIN.
  - Otherwise advance:
    - AW → RG.
    - RG → AR if `rnw`, else DT.
    - AR → DT.
    - DT: a read pulses `rdat_vld` with `rdat=m_dat_in`. If `cnt==0` go to FIN, else decrement `cnt`.
  - Entering DT-write, or continuing within it, goes through FETCH. All other advances go to ISSUE.
- FETCH: `wdat_rdy=1`. On `wdat_vld`, capture the byte and go to ISSUE. Stalls indefinitely while the host supplies nothing (bus held with SCL low).
- ABORT: issue the STOP-only command (`C_STOP`) by the ISSUE rules, then go to ABWAIT. ABWAIT waits for DON, ignores its result, and goes to FIN.
- FIN: `done=1` and `busy=0` for one cycle, then go to IDLE.
- `go` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, `err=0`, state IDLE.
- Reset mid-transfer: the sequencer returns to IDLE next cycle with no STOP issued. The master is left as is; the next transfer's ISSUE naturally waits for BSY to clear.
- `go` accepted at edge N → `busy=1` from N+1; earliest `m_ws` at N+2.
- `m_ws` is exactly one cycle wide, never asserted while `m_stat[SB_BSY]==1`, and at most one strobe is in flight.
- `m_cmd`/`m_dat` are registered and stable while `m_ws` is high. Their value outside a strobe is don't-care; implementation holds the last value.
- `rdat_vld` fires in the EVAL cycle; `done` follows no earlier than the next cycle.
- `wdat_rdy` is high only in FETCH; a transfer consumes exactly `len+1` bytes when it completes without error.
- Boundary cases:
  - `len=0` → single-byte transfers.
  - `len=2^MAXLEN_LD-1` → `cnt` must not wrap before the final byte.

## Test plan
- Write, dev 0x50, reg 0x10, len 1, data 0xA5, 0x5A; the slave model ACKs all bytes → bus shows START, 0xA0, 0x10, 0xA5, 0x5A, STOP; `done` pulses, `err=0`, 2 `wdat` handshakes.
- Read, dev 0x50, reg 0x20, len 2; the slave returns 0x11, 0x22, 0x33 → bus shows START, 0xA0, 0x20, rSTART, 0xA1, 3 reads with the last NACKed, STOP; `rdat_vld` fires 3 times with 0x11, 0x22, 0x33; `err=0`.
- Address NACK (no slave at 0x51) → `err=1`, STOP issued, no `wdat_rdy` and no `rdat_vld`, `done` pulses.
- Data NACK on the 2nd of 4 write bytes → `err=2`, STOP follows, exactly 2 bytes consumed.
- Second master holds SDA low during the address → `err=3`, no STOP issued by the sequencer, `busy` falls.
- `rst` pulsed during a read data phase → all outputs 0 the next cycle; a following write transfer completes with `err=0`.

Source files
------------

// File: rtl/i2c_regxfer.sv
// Register-transfer sequencer for i2c_master: turns one host request (dev, reg, dir, len)
// into START/address/pointer/rSTART/data/STOP byte commands and reports one result code.
module i2c_regxfer #(
  parameter int MAXLEN_LD = 4,
  parameter int C_SZ      = 5,
  parameter int S_SZ      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [6:0]           dev,
  input  logic [7:0]           rega,
  input  logic                 rnw,
  input  logic [MAXLEN_LD-1:0] len,
  input  logic [7:0]           wdat,
  input  logic                 wdat_vld,
  output logic                 wdat_rdy,
  output logic [7:0]           rdat,
  output logic                 rdat_vld,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           err,
  output logic [C_SZ-1:0]      m_cmd,
  output logic [7:0]           m_dat,
  output logic                 m_ws,
  input  logic [S_SZ-1:0]      m_stat,
  input  logic [7:0]           m_dat_in
);

  localparam logic [C_SZ-1:0] C_STRT = C_SZ'(1);
  localparam logic [C_SZ-1:0] C_STOP = C_SZ'(2);
  localparam logic [C_SZ-1:0] C_WRTE = C_SZ'(4);
  localparam logic [C_SZ-1:0] C_READ = C_SZ'(8);
  localparam logic [C_SZ-1:0] C_NACK = C_SZ'(16);
  localparam int SB_BSY = 0;
  localparam int SB_DON = 1;
  localparam int SB_ACK = 2;
  localparam int SB_ALO = 3;
  localparam int SB_BBL = 4;
  localparam int SB_ERR = 5;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ISSUE, ST_SETTLE, ST_WAIT, ST_EVAL, ST_FETCH, ST_ABORT, ST_ABWAIT, ST_FIN
  } state_t;
  typedef enum logic [1:0] {PH_AW, PH_RG, PH_AR, PH_DT} phase_t;

  state_t               r_state, w_nxt;
  phase_t               r_phase, w_ph_nxt;
  logic [MAXLEN_LD-1:0] r_cnt;
  logic [6:0]           r_dev;
  logic [7:0]           r_rega, r_wbyte, r_dat;
  logic                 r_rnw, r_ws;
  logic [C_SZ-1:0]      r_cmd, w_cmd;
  logic [7:0]           w_dat;
  logic [2:0]           r_err, w_errc;
  logic                 w_last, w_fail, w_nack, w_issue, w_dt_rd;

  assign w_last  = (r_cnt == '0);
  assign w_dt_rd = (r_phase == PH_DT) && r_rnw;
  assign w_fail  = m_stat[SB_ALO] | m_stat[SB_BBL] | m_stat[SB_ERR];
  assign w_nack  = !w_dt_rd && !m_stat[SB_ACK];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (go) w_nxt = ST_ISSUE;
      ST_ISSUE:  if (!m_stat[SB_BSY]) w_nxt = ST_SETTLE;
      ST_SETTLE: w_nxt = ST_WAIT;
      ST_WAIT:   if (m_stat[SB_DON] && !m_stat[SB_BSY]) w_nxt = ST_EVAL;
      ST_EVAL: begin
        if (w_fail)
          w_nxt = ST_FIN;
        else if (w_nack)
          // A NACKed last write byte already carried its STOP
          w_nxt = (r_phase == PH_DT && !r_rnw && w_last) ? ST_FIN : ST_ABORT;
        else if (r_phase == PH_DT && w_last)
          w_nxt = ST_FIN;
        else if (w_ph_nxt == PH_DT && !r_rnw)
          w_nxt = ST_FETCH;
        else
          w_nxt = ST_ISSUE;
      end
      ST_FETCH:  if (wdat_vld) w_nxt = ST_ISSUE;
      ST_ABORT:  if (!m_stat[SB_BSY]) w_nxt = ST_ABWAIT;
      // The strobe cycle still shows the previous command's status
      ST_ABWAIT: if (!r_ws && m_stat[SB_DON] && !m_stat[SB_BSY]) w_nxt = ST_FIN;
      ST_FIN:    w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ph_nxt = r_phase;
    w_cmd    = C_WRTE;
    w_dat    = r_rega;
    w_errc   = 3'd2;
    unique case (r_phase)
      PH_AW: begin w_ph_nxt = PH_RG; w_cmd = C_STRT | C_WRTE; w_dat = {r_dev, 1'b0}; end
      PH_RG: begin w_ph_nxt = r_rnw ? PH_AR : PH_DT; end
      PH_AR: begin w_ph_nxt = PH_DT; w_cmd = C_STRT | C_WRTE; w_dat = {r_dev, 1'b1}; end
      PH_DT: begin
        w_dat = r_wbyte;
        if (r_rnw) w_cmd = C_READ | (w_last ? (C_NACK | C_STOP) : '0);
        else       w_cmd = C_WRTE | (w_last ? C_STOP : '0);
      end
      default: ;
    endcase
    if (r_state == ST_ABORT) begin
      w_cmd = C_STOP;
      w_dat = r_dat;
    end
    if      (m_stat[SB_ALO]) w_errc = 3'd3;
    else if (m_stat[SB_BBL]) w_errc = 3'd4;
    else if (m_stat[SB_ERR]) w_errc = 3'd5;
    else if (r_phase == PH_AW || r_phase == PH_AR) w_errc = 3'd1;
    w_issue  = (r_state == ST_ISSUE || r_state == ST_ABORT) && !m_stat[SB_BSY];
    busy     = (r_state != ST_IDLE) && (r_state != ST_FIN);
    done     = (r_state == ST_FIN);
    wdat_rdy = (r_state == ST_FETCH);
    rdat_vld = (r_state == ST_EVAL) && !w_fail && w_dt_rd;
    rdat     = rdat_vld ? m_dat_in : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH_AW;
      r_cnt   <= '0;
      r_dev   <= '0;
      r_rega  <= '0;
      r_rnw   <= 1'b0;
      r_wbyte <= '0;
      r_err   <= '0;
      r_ws    <= 1'b0;
      r_cmd   <= '0;
      r_dat   <= '0;
    end else begin
      r_ws <= w_issue;
      if (w_issue) begin
        r_cmd <= w_cmd;
        r_dat <= w_dat;
      end
      unique case (r_state)
        ST_IDLE: if (go) begin
          r_dev   <= dev;
          r_rega  <= rega;
          r_rnw   <= rnw;
          r_cnt   <= len;
          r_err   <= '0;
          r_phase <= PH_AW;
        end
        ST_FETCH: if (wdat_vld) r_wbyte <= wdat;
        ST_EVAL: begin
          if (w_fail || w_nack) r_err <= w_errc;
          else begin
            r_phase <= w_ph_nxt;
            if (r_phase == PH_DT && !w_last) r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign err   = r_err;
  assign m_ws  = r_ws;
  assign m_cmd = r_cmd;
  assign m_dat = r_dat;

endmodule

// File: tb/tb_i2c_regxfer.sv
// Scoreboard bench for i2c_regxfer: directed transfers against a byte-level master model;
// a negedge monitor pops expected strobes / read bytes / done codes in order.
module tb_i2c_regxfer;
  localparam int LD = 4;
  localparam logic [4:0] C_STRT = 5'h01, C_STOP = 5'h02, C_WRTE = 5'h04,
                         C_READ = 5'h08, C_NACK = 5'h10;

  logic          clk = 0, rst = 1, go = 0, rnw = 0, wdat_vld = 0;
  logic [6:0]    dev = 0;
  logic [7:0]    rega = 0, wdat = 0, m_dat_in = 0;
  logic [LD-1:0] len = 0;
  logic          wdat_rdy, rdat_vld, busy, done, m_ws;
  logic [7:0]    rdat, m_dat;
  logic [2:0]    err;
  logic [4:0]    m_cmd;
  logic [5:0]    m_stat;

  i2c_regxfer #(.MAXLEN_LD(LD), .C_SZ(5), .S_SZ(6)) dut (
    .clk(clk), .rst(rst), .go(go), .dev(dev), .rega(rega), .rnw(rnw), .len(len),
    .wdat(wdat), .wdat_vld(wdat_vld), .wdat_rdy(wdat_rdy), .rdat(rdat), .rdat_vld(rdat_vld),
    .busy(busy), .done(done), .err(err), .m_cmd(m_cmd), .m_dat(m_dat), .m_ws(m_ws),
    .m_stat(m_stat), .m_dat_in(m_dat_in));

  always #5 clk = ~clk;

  typedef struct {int kind; logic [4:0] cmd; logic [7:0] dat; bit chk;} ev_t;
  typedef struct {bit ack; bit alo; logic [7:0] rd;} rsp_t;
  ev_t        exp_q[$];
  rsp_t       rsp_q[$];
  logic [7:0] wq[$];
  int ncmp = 0, nerr = 0, hs_cnt = 0, rd_cnt = 0, done_cnt = 0, rdy_cyc = 0;

  task automatic chk(string nm, int act, int expv);
    ncmp++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
    end
  endtask

  // Byte-level master model: a strobe raises BSY, clears DON; 3 cycles later DON with the scripted result
  logic m_bsy = 0, m_don = 0, m_ack = 0, m_alo = 0;
  int   m_ctr = 0;
  rsp_t m_cur;
  assign m_stat = {1'b0, 1'b0, m_alo, m_ack, m_don, m_bsy};
  always @(posedge clk) begin
    if (m_ws) begin
      if (rsp_q.size() != 0) m_cur = rsp_q.pop_front();
      else m_cur = '{1'b1, 1'b0, 8'h00};
      m_bsy <= 1'b1;
      m_don <= 1'b0;
      m_ctr = 3;
    end else if (m_bsy) begin
      m_ctr--;
      if (m_ctr == 0) begin
        m_bsy    <= 1'b0;
        m_don    <= 1'b1;
        m_ack    <= m_cur.ack;
        m_alo    <= m_cur.alo;
        m_dat_in <= m_cur.rd;
      end
    end
  end

  // Write-data source
  always @(posedge clk) begin
    if (wdat_vld && wdat_rdy) begin
      hs_cnt++;
      if (wq.size() != 0) void'(wq.pop_front());
    end
    #1;
    wdat_vld = (wq.size() != 0);
    wdat     = (wq.size() != 0) ? wq[0] : 8'h00;
  end

  task automatic take(int k, logic [4:0] c, logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", k, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", k, e.kind);
    if (k == e.kind) begin
      if (k == 0) begin
        chk("m_cmd", int'(c), int'(e.cmd));
        if (e.chk) chk("m_dat", int'(d), int'(e.dat));
      end else if (k == 1) chk("rdat", int'(d), int'(e.dat));
      else chk("done_err", int'(d), int'(e.dat));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wdat_rdy) rdy_cyc++;
      if (m_ws) begin
        chk("ws_while_bsy", int'(m_bsy), 0);
        take(0, m_cmd, m_dat);
      end
      if (rdat_vld) begin rd_cnt++; take(1, 5'h0, rdat); end
      if (done) begin done_cnt++; take(2, 5'h0, {5'b0, err}); end
    end
  end

  task automatic ew(logic [4:0] c, logic [7:0] d, bit ck);
    ev_t e; e.kind = 0; e.cmd = c; e.dat = d; e.chk = ck; exp_q.push_back(e);
  endtask
  task automatic er(logic [7:0] d);
    ev_t e; e.kind = 1; e.cmd = 0; e.dat = d; e.chk = 1; exp_q.push_back(e);
  endtask
  task automatic ed(logic [2:0] code);
    ev_t e; e.kind = 2; e.cmd = 0; e.dat = {5'b0, code}; e.chk = 1; exp_q.push_back(e);
  endtask
  task automatic rs(bit ack, bit alo, logic [7:0] rd);
    rsp_t r; r.ack = ack; r.alo = alo; r.rd = rd; rsp_q.push_back(r);
  endtask

  task automatic start(logic [6:0] d, logic [7:0] r, bit rd, logic [LD-1:0] n);
    @(posedge clk); #1;
    dev = d; rega = r; rnw = rd; len = n; go = 1;
    @(posedge clk); #1;
    go = 0;
    chk("busy_after_go", int'(busy), 1);
  endtask

  task automatic finish(string nm, int d0, logic [2:0] code);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    #1;
    chk({nm, "_done_seen"}, done_cnt - d0, 1);
    chk({nm, "_busy_low"}, int'(busy), 0);
    chk({nm, "_err_held"}, int'(err), int'(code));
    chk({nm, "_events_left"}, exp_q.size(), 0);
  endtask

  task automatic addr_ph(logic [6:0] d, logic [7:0] r);
    ew(C_STRT | C_WRTE, {d, 1'b0}, 1); ew(C_WRTE, r, 1);
    rs(1, 0, 0); rs(1, 0, 0);
  endtask

  int d0, h0, r0, y0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", int'({busy, done, wdat_rdy, rdat_vld, m_ws, err, m_cmd, m_dat, rdat}), 0);
    rst = 0;

    // Write two bytes
    addr_ph(7'h50, 8'h10);
    ew(C_WRTE, 8'hA5, 1); ew(C_WRTE | C_STOP, 8'h5A, 1); ed(0);
    rs(1, 0, 0); rs(1, 0, 0);
    wq.push_back(8'hA5); wq.push_back(8'h5A);
    d0 = done_cnt; h0 = hs_cnt;
    start(7'h50, 8'h10, 0, 1);
    finish("wr2", d0, 0);
    chk("wr2_handshakes", hs_cnt - h0, 2);

    // Read three bytes with repeated START
    addr_ph(7'h50, 8'h20);
    ew(C_STRT | C_WRTE, 8'hA1, 1); rs(1, 0, 0);
    ew(C_READ, 0, 0); er(8'h11); ew(C_READ, 0, 0); er(8'h22);
    ew(C_READ | C_NACK | C_STOP, 0, 0); er(8'h33); ed(0);
    rs(1, 0, 8'h11); rs(1, 0, 8'h22); rs(1, 0, 8'h33);
    d0 = done_cnt; r0 = rd_cnt;
    start(7'h50, 8'h20, 1, 2);
    finish("rd3", d0, 0);
    chk("rd3_count", rd_cnt - r0, 3);

    // Address NACK
    ew(C_STRT | C_WRTE, 8'hA2, 1); ew(C_STOP, 0, 0); ed(1);
    rs(0, 0, 0); rs(1, 0, 0);
    wq.push_back(8'hEE);
    d0 = done_cnt; r0 = rd_cnt; y0 = rdy_cyc;
    start(7'h51, 8'h10, 0, 0);
    finish("anack", d0, 1);
    chk("anack_no_rdy", rdy_cyc - y0, 0);
    chk("anack_no_rdat", rd_cnt - r0, 0);
    wq.delete();
    repeat (2) @(posedge clk);

    // Data NACK on the 2nd of 4 bytes
    addr_ph(7'h50, 8'h30);
    ew(C_WRTE, 8'h01, 1); ew(C_WRTE, 8'h02, 1); ew(C_STOP, 0, 0); ed(2);
    rs(1, 0, 0); rs(0, 0, 0); rs(1, 0, 0);
    for (int i = 1; i <= 4; i++) wq.push_back(8'(i));
    d0 = done_cnt; h0 = hs_cnt;
    start(7'h50, 8'h30, 0, 3);
    finish("dnack", d0, 2);
    chk("dnack_handshakes", hs_cnt - h0, 2);
    wq.delete();
    repeat (2) @(posedge clk);

    // Arbitration lost during address: no STOP from the sequencer
    ew(C_STRT | C_WRTE, 8'hA0, 1); ed(3);
    rs(0, 1, 0);
    wq.push_back(8'h77);
    d0 = done_cnt;
    start(7'h50, 8'h40, 0, 0);
    finish("alo", d0, 3);
    wq.delete();
    repeat (2) @(posedge clk);

    // Single-byte read
    addr_ph(7'h50, 8'h21);
    ew(C_STRT | C_WRTE, 8'hA1, 1); rs(1, 0, 0);
    ew(C_READ | C_NACK | C_STOP, 0, 0); er(8'h9C); ed(0);
    rs(1, 0, 8'h9C);
    d0 = done_cnt;
    start(7'h50, 8'h21, 1, 0);
    finish("rd1", d0, 0);

    // Maximum length write: 16 bytes, count must not wrap early
    addr_ph(7'h28, 8'hF0);
    for (int i = 0; i < 16; i++) begin
      ew((i == 15) ? (C_WRTE | C_STOP) : C_WRTE, 8'(i * 17), 1);
      rs(1, 0, 0);
      wq.push_back(8'(i * 17));
    end
    ed(0);
    d0 = done_cnt; h0 = hs_cnt;
    start(7'h28, 8'hF0, 0, 4'hF);
    finish("wr16", d0, 0);
    chk("wr16_handshakes", hs_cnt - h0, 16);

    // Reset during the read data phase
    addr_ph(7'h50, 8'h20);
    ew(C_STRT | C_WRTE, 8'hA1, 1); rs(1, 0, 0);
    ew(C_READ, 0, 0); er(8'h11); ew(C_READ, 0, 0); er(8'h22);
    rs(1, 0, 8'h11); rs(1, 0, 8'h22);
    r0 = rd_cnt;
    start(7'h50, 8'h20, 1, 2);
    for (int i = 0; i < 3000 && rd_cnt == r0; i++) @(posedge clk);
    chk("rst_first_rdat_seen", rd_cnt - r0, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    exp_q.delete();
    rsp_q.delete();
    @(negedge clk);
    chk("rst_mid_outs", int'({busy, done, wdat_rdy, rdat_vld, m_ws, err, m_cmd, m_dat, rdat}), 0);
    rst = 0;
    repeat (3) @(posedge clk);

    addr_ph(7'h50, 8'h10);
    ew(C_WRTE, 8'hC3, 1); ew(C_WRTE | C_STOP, 8'h3C, 1); ed(0);
    rs(1, 0, 0); rs(1, 0, 0);
    wq.push_back(8'hC3); wq.push_back(8'h3C);
    d0 = done_cnt; h0 = hs_cnt;
    start(7'h50, 8'h10, 0, 1);
    finish("post_rst", d0, 0);
    chk("post_rst_handshakes", hs_cnt - h0, 2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
